// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory image loader: loader FSM states,
// instruction width and the default instruction-memory address width.
package imem_loader_pkg;

    localparam int INSTR_W     = 32;
    localparam int IMEM_ADDR_W = 8;
    localparam int LEN_W       = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN0 = 3'd1,
        LEN1 = 3'd2,
        DATA = 3'd3,
        LAST = 3'd4,
        RUN  = 3'd5,
        ERR  = 3'd6
    } loader_state_e;

    function automatic logic state_is_busy(input loader_state_e s);
        logic res;
        case (s)
            LEN0, LEN1, DATA, LAST: res = 1'b1;
            default:                res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream plus instruction-memory write port, bundled for the loader.
// The master side is the loader itself; the slave side is the host/memory environment.
interface imem_loader_if
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
) ();

    logic               in_valid;
    logic [7:0]         in_byte;
    logic               in_ready;
    logic               imem_we;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_wdata;

    modport master (
        input  in_valid,
        input  in_byte,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport slave (
        output in_valid,
        output in_byte,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

endinterface

// File: rtl/imem_word_packer.sv
// Little-endian 4-byte word assembler. word_valid flags the byte that completes a
// word, and word_data carries that byte merged with the three held lower bytes.
module imem_word_packer
    import imem_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               word_valid,
    output logic [INSTR_W-1:0] word_data
);

    logic [1:0]  byte_cnt_r;
    logic [23:0] low_bytes_r;

    // Completion is flagged in the same cycle as the 4th byte so the caller can register the write
    always_comb begin
        word_valid = byte_valid && (byte_cnt_r == 2'd3);
        word_data  = {byte_data, low_bytes_r};
    end

    // Byte lane capture and byte counter
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt_r  <= 2'd0;
            low_bytes_r <= 24'd0;
        end else if (clr) begin
            byte_cnt_r  <= 2'd0;
            low_bytes_r <= 24'd0;
        end else if (byte_valid) begin
            case (byte_cnt_r)
                2'd0:    low_bytes_r[7:0]   <= byte_data;
                2'd1:    low_bytes_r[15:8]  <= byte_data;
                2'd2:    low_bytes_r[23:16] <= byte_data;
                default: low_bytes_r        <= low_bytes_r;
            endcase
            byte_cnt_r <= byte_cnt_r + 2'd1;
        end else begin
            byte_cnt_r  <= byte_cnt_r;
            low_bytes_r <= low_bytes_r;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a byte-serial image (16-bit LE word count, then LE 32-bit words) into
// instruction memory and holds the processor in reset until a valid image is loaded.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    imem_loader_if.master bus,
    output logic          cpu_rst,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

    loader_state_e      state_r;
    loader_state_e      state_next_s;
    logic [LEN_W-1:0]   len_r;
    logic [LEN_W-1:0]   len_full_s;
    logic [ADDR_W:0]    k_r;
    logic               in_ready_s;
    logic               accept_s;
    logic               pack_clr_s;
    logic               pack_valid_s;
    logic               word_valid_s;
    logic [INSTR_W-1:0] word_s;
    logic               last_word_s;

    logic               imem_we_r;
    logic [ADDR_W-1:0]  imem_addr_r;
    logic [INSTR_W-1:0] imem_wdata_r;
    logic               cpu_rst_r;
    logic               busy_r;
    logic               done_r;
    logic               err_r;

    // in_ready is a pure state decode so the host never sees a combinational path from in_valid
    always_comb begin
        case (state_r)
            LEN0, LEN1, DATA: in_ready_s = 1'b1;
            default:          in_ready_s = 1'b0;
        endcase
    end

    assign accept_s     = bus.in_valid && in_ready_s;
    assign pack_clr_s   = (state_r != DATA);
    assign pack_valid_s = accept_s && (state_r == DATA);
    assign len_full_s   = {bus.in_byte, len_r[7:0]};
    assign last_word_s  = (LEN_W'(k_r) == (len_r - 16'd1));

    imem_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (pack_clr_s),
        .byte_valid (pack_valid_s),
        .byte_data  (bus.in_byte),
        .word_valid (word_valid_s),
        .word_data  (word_s)
    );

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE, RUN, ERR: begin
                if (start) begin
                    state_next_s = LEN0;
                end else begin
                    state_next_s = state_r;
                end
            end
            LEN0: begin
                if (accept_s) begin
                    state_next_s = LEN1;
                end else begin
                    state_next_s = LEN0;
                end
            end
            LEN1: begin
                if (!accept_s) begin
                    state_next_s = LEN1;
                end else if (len_full_s == 16'd0) begin
                    state_next_s = RUN;
                end else if ({16'd0, len_full_s} > DEPTH) begin
                    state_next_s = ERR;
                end else begin
                    state_next_s = DATA;
                end
            end
            DATA: begin
                if (word_valid_s && last_word_s) begin
                    state_next_s = LAST;
                end else begin
                    state_next_s = DATA;
                end
            end
            LAST:    state_next_s = RUN;
            default: state_next_s = IDLE;
        endcase
    end

    // State, length/index capture and registered outputs (decoded from the next state)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            len_r        <= 16'd0;
            k_r          <= {(ADDR_W+1){1'b0}};
            imem_we_r    <= 1'b0;
            imem_addr_r  <= {ADDR_W{1'b0}};
            imem_wdata_r <= 32'd0;
            cpu_rst_r    <= 1'b1;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            imem_we_r <= word_valid_s;
            if (word_valid_s) begin
                imem_addr_r  <= k_r[ADDR_W-1:0];
                imem_wdata_r <= word_s;
                k_r          <= k_r + (ADDR_W+1)'(1);
            end else if ((state_r == LEN1) && accept_s) begin
                k_r <= {(ADDR_W+1){1'b0}};
            end else begin
                k_r <= k_r;
            end
            if ((state_r == LEN0) && accept_s) begin
                len_r[7:0] <= bus.in_byte;
            end else if ((state_r == LEN1) && accept_s) begin
                len_r[15:8] <= bus.in_byte;
            end else begin
                len_r <= len_r;
            end
            cpu_rst_r <= (state_next_s != RUN);
            busy_r    <= state_is_busy(state_next_s);
            done_r    <= (state_next_s == RUN);
            err_r     <= (state_next_s == ERR);
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.imem_we    = imem_we_r;
    assign bus.imem_addr  = imem_addr_r;
    assign bus.imem_wdata = imem_wdata_r;
    assign cpu_rst        = cpu_rst_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign err            = err_r;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised scoreboard bench for imem_loader: an image-level model predicts the
// memory writes, and a negedge monitor compares every observed write strobe.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int AW    = 8;
    localparam int DEPTH = 256;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic cpu_rst, busy, done, err;

    imem_loader_if #(.ADDR_W(AW)) bus ();

    imem_loader #(.ADDR_W(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bus     (bus),
        .cpu_rst (cpu_rst),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          failed = 0;
    int          cyc = 0;
    int          consumed = 0;
    int          wr_count = 0;
    wr_t         exp_q[$];
    int          wr_cyc[$];
    logic [7:0]  img[$];
    logic [31:0] mem[DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: write strobes and consumed bytes, sampled mid-cycle
    always @(negedge clk) begin
        wr_t e;
        if (!rst && bus.in_valid && bus.in_ready) consumed++;
        if (bus.imem_we) begin
            wr_count++;
            wr_cyc.push_back(cyc);
            mem[bus.imem_addr] = bus.imem_wdata;
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.imem_addr), 32'(e.addr));
                check("wr_data", bus.imem_wdata, e.data);
            end
        end
    end

    // Image-level model: word k occupies bytes 4k+2..4k+5, written only for a legal count
    task automatic push_expected();
        int  n;
        wr_t e;
        n = int'({img[1], img[0]});
        if (n >= 1 && n <= DEPTH) begin
            for (int k = 0; k < n; k++) begin
                if (4 * k + 5 < img.size()) begin
                    e.addr = k[AW-1:0];
                    e.data = {img[4*k+5], img[4*k+4], img[4*k+3], img[4*k+2]};
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic build_words(input int n_field, input int n_words, input bit inc);
        logic [31:0] w;
        img.delete();
        img.push_back(n_field[7:0]);
        img.push_back(n_field[15:8]);
        for (int i = 0; i < n_words; i++) begin
            w = inc ? 32'(i) : $urandom();
            for (int j = 0; j < 4; j++) img.push_back(w[8*j +: 8]);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall, input bit with_start);
        int guard = 0;
        for (int s = 0; s < 8 && stall && ($urandom_range(0, 1) == 1); s++) begin
            bus.in_valid = 1'b0;
            bus.in_byte  = $urandom();
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        start        = with_start;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk); #1;
            start = 1'b0;
            guard++;
        end
        if (guard >= 50) begin
            tests++;
            failed++;
            $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles, expected 1", guard);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_imem_we"}, 32'(bus.imem_we), 32'd0);
        check({tag, "_imem_addr"}, 32'(bus.imem_addr), 32'd0);
        check({tag, "_imem_wdata"}, bus.imem_wdata, 32'd0);
        check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    // Full load of img; timing checks are exact relative to the final accepted byte
    task automatic run_image(input bit stall, input int start_at);
        int n;
        consumed = 0;
        wr_cyc.delete();
        pulse_start();
        check("len0_in_ready", 32'(bus.in_ready), 32'd1);
        check("len0_cpu_rst", 32'(cpu_rst), 32'd1);
        check("len0_busy", 32'(busy), 32'd1);
        push_expected();
        n = int'({img[1], img[0]});
        for (int i = 0; i < img.size(); i++) send_byte(img[i], stall, i == start_at);
        bus.in_valid = 1'b0;
        if (n == 0) begin
            check("empty_done", 32'(done), 32'd1);
            check("empty_cpu_rst", 32'(cpu_rst), 32'd0);
        end else if (n > DEPTH) begin
            check("ovr_err", 32'(err), 32'd1);
            check("ovr_in_ready", 32'(bus.in_ready), 32'd0);
            check("ovr_cpu_rst", 32'(cpu_rst), 32'd1);
            check("ovr_busy", 32'(busy), 32'd0);
        end else begin
            check("last_cpu_rst", 32'(cpu_rst), 32'd1);
            check("last_we", 32'(bus.imem_we), 32'd1);
            @(posedge clk); #1;
            check("run_done", 32'(done), 32'd1);
            check("run_cpu_rst", 32'(cpu_rst), 32'd0);
        end
        check("bytes_consumed", 32'(consumed), 32'(img.size()));
        @(posedge clk); #1;
        check("sb_drained", 32'(exp_q.size()), 32'd0);
    endtask

    logic [7:0] basic_img [10] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00,
                                   8'h93, 8'h00, 8'hA0, 8'h00};

    initial begin
        int          wc;
        logic [31:0] new_word;
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic back-to-back load
        img.delete();
        for (int i = 0; i < 10; i++) img.push_back(basic_img[i]);
        run_image(1'b0, -1);
        check("basic_wr_cnt", 32'(wr_cyc.size()), 32'd2);
        if (wr_cyc.size() == 2) check("basic_wr_spacing", 32'(wr_cyc[1] - wr_cyc[0]), 32'd4);
        check("basic_mem0", mem[0], 32'h00500013);
        check("basic_mem1", mem[1], 32'h00A00093);

        // Same image with a stalling host (reload from RUN)
        mem[0] = 32'd0;
        mem[1] = 32'd0;
        run_image(1'b1, -1);
        check("stall_mem0", mem[0], 32'h00500013);
        check("stall_mem1", mem[1], 32'h00A00093);

        // Reset in the middle of word 1
        build_words(3, 3, 1'b0);
        while (img.size() > 8) void'(img.pop_back());
        pulse_start();
        push_expected();
        for (int i = 0; i < img.size(); i++) send_byte(img[i], 1'b1, 1'b0);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset("rst_a");
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset("rst_b");
        wc = wr_count;
        repeat (20) @(posedge clk);
        #1;
        check("rst_no_write", 32'(wr_count - wc), 32'd0);
        check("rst_sb_drained", 32'(exp_q.size()), 32'd0);
        check("rst_idle_cpu_rst", 32'(cpu_rst), 32'd1);
        check("rst_idle_busy", 32'(busy), 32'd0);

        // Empty image from IDLE
        wc = wr_count;
        build_words(0, 0, 1'b0);
        run_image(1'b1, -1);
        check("empty_no_write", 32'(wr_count - wc), 32'd0);

        // Full-depth image of incrementing words
        build_words(256, 256, 1'b1);
        run_image(1'b0, -1);
        check("full_wr_cnt", 32'(wr_cyc.size()), 32'd256);
        check("full_mem0", mem[0], 32'd0);
        check("full_mem255", mem[255], 32'd255);

        // Oversize count, then recovery with a one-word image
        wc = wr_count;
        build_words(257, 0, 1'b0);
        run_image(1'b0, -1);
        check("ovr_no_write", 32'(wr_count - wc), 32'd0);
        build_words(1, 1, 1'b0);
        run_image(1'b1, -1);
        check("recover_done", 32'(done), 32'd1);

        // start pulse during DATA must be ignored
        build_words(3, 3, 1'b0);
        run_image(1'b0, 6);
        check("ign_done", 32'(done), 32'd1);

        // Reload from RUN overwrites addr 0 only
        build_words(1, 1, 1'b0);
        new_word = {img[5], img[4], img[3], img[2]};
        run_image(1'b1, -1);
        check("reload_mem0", mem[0], new_word);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that streams a byte-serial image from a host into the pipeline processor's instruction memory, replacing the simulation-only memory preload. It sits between a host byte source and the instruction memory write port. It holds the processor in reset until the image is fully written, then releases it. Image format: 16-bit little-endian word count N, then N 32-bit little-endian instruction words.

## Interface

Parameters:
- ADDR_W, 8: instruction memory word-address width; DEPTH = 2**ADDR_W words.

Ports:
- clk  in  1  system clock; every register updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  single-cycle request to begin a load; honoured only in IDLE, RUN or ERR.
- in_valid  in  1  host byte available.
- in_byte  in  8  host byte.
- in_ready  out  1  loader accepts a byte; a transfer occurs when in_valid && in_ready.
- imem_we  out  1  instruction memory write strobe; one cycle per word.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  instruction word.
- cpu_rst  out  1  processor reset; high whenever no valid image is loaded.
- busy  out  1  high in LEN0, LEN1, DATA, LAST.
- done  out  1  high in RUN.
- err  out  1  high in ERR.

## Operation

- States: IDLE, LEN0, LEN1, DATA, LAST, RUN, ERR.
- IDLE: cpu_rst=1, in_ready=0. start -> LEN0.
- LEN0: in_ready=1; the accepted byte becomes N[7:0]; -> LEN1.
- LEN1: in_ready=1; the accepted byte becomes N[15:8]. If N==0 -> RUN (no writes). If N>DEPTH -> ERR. Otherwise -> DATA, with word index k=0 and byte index b=0.
- DATA: in_ready=1. Accepted byte b goes to word bits [8b+7:8b]; b increments.
  - On the 4th byte (b==3): the word is registered for writing at index k; b returns to 0; k increments.
  - If k==N-1 at that point -> LAST, else stay in DATA.
- LAST: in_ready=0. The final word's write strobe is presented here; -> RUN.
- RUN: cpu_rst=0, done=1, in_ready=0. start -> LEN0 with cpu_rst=1 the next cycle.
- ERR: cpu_rst=1, err=1, in_ready=0, no writes. start -> LEN0.
- start is ignored in LEN0, LEN1, DATA and LAST.
- Bytes presented while in_ready=0 are not consumed.
- Arithmetic and widths:
  - N is unsigned 16-bit.
  - k is ADDR_W+1 bits; imem_addr = k[ADDR_W-1:0].
  - N==DEPTH is legal; the last address written is DEPTH-1.
- Memory contents are never cleared by the loader; a reload overwrites only addresses 0..N-1.
- rst at any time: the next cycle shows reset values and the FSM is in IDLE. No write strobe appears after a reset edge, including a write that was pending.
- Reset values: state IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, busy=0, done=0, err=0.

## Timing

- All outputs are registered, except in_ready, which is decoded from state only and never depends on in_valid.
- Write latency: when the 4th byte of word k is accepted at edge t, imem_we=1 with addr k and the assembled data during cycle t+1. The strobe lasts exactly one cycle.
- Back-to-back input: a new byte is accepted every cycle in DATA, including the cycle in which the previous word's strobe is high. Sustained rate is one word per 4 cycles.
- Last word: accepted at edge t; the LAST-state write occurs in cycle t+1; RUN (cpu_rst=0, done=1) begins in cycle t+2.
- N==0: the LEN1 byte is accepted at t; RUN begins in cycle t+1.
- start in IDLE/RUN/ERR at edge t: LEN0 state, in_ready=1 and cpu_rst=1 hold in cycle t+1.

## Structure

- Shared pipeline package:
  - loader_state_e enum (the seven states).
  - INSTR_W=32.
  - IMEM_ADDR_W default 8.
- One sub-module, imem_word_packer: a 4-byte little-endian assembler with a byte counter, clear input and word_valid pulse. The FSM, length capture, bounds check and address counter stay in imem_loader.

## Test plan

- Reset: assert rst 2 cycles mid-stream. Required response: reset values; no imem_we for 20 cycles afterwards without start.
- Basic load: start, then back-to-back bytes 02 00 13 00 50 00 93 00 A0 00. Required response: imem_we at addr 0 with 0x00500013, then addr 1 with 0x00A00093, 4 cycles apart; cpu_rst falls 2 cycles after the last byte.
- Stalled host: the same image with in_valid low on random cycles (~50%). Required response: identical writes, and no byte consumed while in_valid=0.
- Empty and full: N=0 gives RUN 1 cycle after LEN1 with zero writes. N=256 of incrementing words writes addrs 0..255 and reaches RUN.
- Oversize: bytes 01 01 (N=257). Required response: ERR next cycle, err=1, in_ready=0, cpu_rst=1. A following start plus a valid 1-word image reaches RUN.
- Ignored start / reload: a start pulse during DATA has no effect. A start in RUN raises cpu_rst the next cycle, and the reload overwrites addr 0.
